adder_sum_splitter: RTL and testbench
=====================================

Name: adder_sum_splitter

Overview:
- Inverse-direction companion of the team's 8-bit registered adder.
- Accepts a 9-bit sum and one 8-bit operand (a), and recovers the other operand (b = sum − a).
- Flags any sum/operand pair that no 8-bit a+b could have produced.
- Sits downstream of the adder output path as a consumer/checker, with valid/ready handshakes on both sides and a 2-entry output buffer so back-pressure never drops data.

Parameters:
- CNT_W, 16, width of the saturating pass/error statistics counters (legal range 4..32).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset: synchronous, active-high.
- clr_cnt  input  1  synchronous clear of pass_cnt/err_cnt.
- in_valid  input  1  input pair valid.
- in_ready  output  1  block can accept a pair this cycle.
- sum_in  input  9  sum to split (adder sum_o format).
- a_in  input  8  known operand.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head entry.
- b_out  output  8  recovered operand.
- err_out  output  1  head entry inconsistent.
- pass_cnt  output  CNT_W  count of accepted consistent pairs.
- err_cnt  output  CNT_W  count of accepted inconsistent pairs.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - FIFO emptied (count=0, read/write pointers 0).
  - pass_cnt=0, err_cnt=0.
  - Output regs b_out=0, err_out=0.
  - After reset: out_valid=0, in_ready=1.
  - rst overrides every other input in the same cycle; data in flight is discarded.
- Transfer rules:
  - Input transfer when in_valid && in_ready at a rising edge.
  - Output transfer when out_valid && out_ready at a rising edge.
- Arithmetic: diff = {1'b0,sum_in} − {2'b00,a_in}, computed 10 bits wide.
  - err = diff[9] (sum<a) OR diff[8] (diff>255).
  - Stored b = err ? 8'h00 : diff[7:0].
- Buffer: 2-entry FIFO of {b, err}.
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - b_out/err_out always present the head entry, and are 0 when empty.
  - No combinational path from in_* to out_*, or from out_ready to in_ready.
- Latency: a pair accepted at edge N into an empty FIFO appears on out_valid/b_out immediately after edge N, i.e. it is visible in cycle N+1.
- Simultaneous push and pop:
  - count=1: count stays 1, head advances to the new entry.
  - count=2: push is blocked (in_ready=0), pop proceeds, count becomes 1; in_ready rises the following cycle.
  - count=0: pop impossible (out_valid=0); push proceeds.
- Pointers: 1-bit read/write pointers that wrap modulo 2; order is strictly FIFO.
- Counters:
  - On each input transfer, increment pass_cnt if err=0, else err_cnt.
  - Both saturate at 2^CNT_W−1; no wrap.
  - clr_cnt=1 zeroes both counters; clear wins over a same-cycle increment.
  - clr_cnt does not affect FIFO contents.
- in_valid with in_ready=0: no state change. The source must hold data stable; the block does not check this.

Test Plan:
- Reset check: assert rst with FIFO holding 2 entries → next cycle out_valid=0, in_ready=1, b_out=0, err_out=0, pass_cnt=err_cnt=0.
- Basic split, out_ready=1: sum_in=9'h12C (300), a_in=8'd100 → one cycle later b_out=200, err_out=0, pass_cnt=1. Then sum_in=9'h1FE, a_in=8'hFF → b_out=8'hFF, err_out=0.
- Error cases:
  - sum_in=9'd5, a_in=8'd10 → err_out=1, b_out=0.
  - sum_in=9'h1FF, a_in=8'h00 → err_out=1, b_out=0.
  - After both, err_cnt=2.
- Back-pressure: out_ready=0, push 3 pairs (b=1,2,3) → in_ready drops after the 2nd accept, 3rd pair held. Raise out_ready → outputs 1,2,3 in order, no loss or duplication; full-plus-pop cycle shows in_ready=0 that cycle, 1 the next.
- Streaming: in_valid=out_ready=1 for 20 cycles with random consistent pairs → one output per cycle, b_out matches the reference model, pass_cnt=20.
- Saturation and clear: CNT_W=4, push 20 error pairs → err_cnt stops at 15. Assert clr_cnt in a cycle that also accepts an error pair → err_cnt=0 next cycle.

Source files
------------

// File: rtl/adder_sum_splitter_if.sv
// adder_sum_splitter_if: valid/ready input pair and output operand channels for the sum splitter
interface adder_sum_splitter_if;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] sum_in;
  logic [7:0] a_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] b_out;
  logic       err_out;
  modport master (output in_valid, sum_in, a_in, out_ready, input in_ready, out_valid, b_out, err_out);
  modport slave (input in_valid, sum_in, a_in, out_ready, output in_ready, out_valid, b_out, err_out);
endinterface

// File: rtl/adder_sum_splitter.sv
// adder_sum_splitter: recovers b = sum - a, flags impossible pairs, 2-entry output FIFO with stats
module adder_sum_splitter #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_cnt,
    adder_sum_splitter_if.slave  s,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     err_cnt
);
    logic [9:0] diff;
    logic       err;
    logic       push;
    logic       pop;
    logic [8:0] mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;

    // Borrow (sum < a) or overflow past 255 means no 8-bit b exists
    assign diff = {1'b0, s.sum_in} - {2'b00, s.a_in};
    assign err = diff[9] | diff[8];
    assign push = s.in_valid && s.in_ready;
    assign pop = s.out_valid && s.out_ready;
    assign s.in_ready = (count != 2'd2);
    assign s.out_valid = (count != 2'd0);
    assign {s.b_out, s.err_out} = s.out_valid ? mem[rd_ptr] : 9'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            mem      <= '{default: '0};
            pass_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {err ? 8'h00 : diff[7:0], err};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
            if (clr_cnt) begin
                pass_cnt <= '0;
                err_cnt  <= '0;
            end else if (push) begin
                if (err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                if (!err && pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_adder_sum_splitter.sv
// tb_adder_sum_splitter: directed checks of splitting, errors, back-pressure, streaming and saturation
module tb_adder_sum_splitter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_cnt = 1'b0;
    logic clr4 = 1'b0;
    logic [15:0] pass_cnt, err_cnt;
    logic [3:0]  pass4, err4;
    int tests = 0;
    int failed = 0;

    adder_sum_splitter_if m ();
    adder_sum_splitter_if m4 ();

    adder_sum_splitter #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .clr_cnt(clr_cnt), .s(m), .pass_cnt(pass_cnt), .err_cnt(err_cnt));
    adder_sum_splitter #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .clr_cnt(clr4), .s(m4), .pass_cnt(pass4), .err_cnt(err4));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] a, b;
        m.in_valid = 0; m.sum_in = '0; m.a_in = '0; m.out_ready = 0;
        m4.in_valid = 0; m4.sum_in = '0; m4.a_in = '0; m4.out_ready = 0;
        step(); step();
        rst = 0;
        // fill FIFO then reset over it
        m.in_valid = 1; m.sum_in = 9'd10; m.a_in = 8'd3;
        step();
        m.sum_in = 9'd20; m.a_in = 8'd5;
        step();
        check("full_valid", m.out_valid, 1);
        check("full_ready", m.in_ready, 0);
        rst = 1; m.in_valid = 0;
        step();
        rst = 0;
        check("rst_out_valid", m.out_valid, 0);
        check("rst_in_ready", m.in_ready, 1);
        check("rst_b", m.b_out, 0);
        check("rst_err", m.err_out, 0);
        check("rst_pass", pass_cnt, 0);
        check("rst_errcnt", err_cnt, 0);
        // basic splits
        m.out_ready = 1; m.in_valid = 1; m.sum_in = 9'h12C; m.a_in = 8'd100;
        step();
        check("b300_100", m.b_out, 200);
        check("e300_100", m.err_out, 0);
        check("v300_100", m.out_valid, 1);
        check("pass1", pass_cnt, 1);
        m.sum_in = 9'h1FE; m.a_in = 8'hFF;
        step();
        check("b1fe_ff", m.b_out, 8'hFF);
        check("e1fe_ff", m.err_out, 0);
        check("pass2", pass_cnt, 2);
        // error cases
        m.sum_in = 9'd5; m.a_in = 8'd10;
        step();
        check("e5_10", m.err_out, 1);
        check("b5_10", m.b_out, 0);
        m.sum_in = 9'h1FF; m.a_in = 8'h00;
        step();
        check("e1ff_0", m.err_out, 1);
        check("b1ff_0", m.b_out, 0);
        check("errcnt2", err_cnt, 2);
        m.in_valid = 0;
        step();
        check("drain_valid", m.out_valid, 0);
        // back-pressure
        m.out_ready = 0; m.in_valid = 1; m.sum_in = 9'd1; m.a_in = 8'd0;
        step();
        check("bp1_ready", m.in_ready, 1);
        m.sum_in = 9'd2;
        step();
        check("bp2_ready", m.in_ready, 0);
        m.sum_in = 9'd3;
        step();
        check("bp_hold_ready", m.in_ready, 0);
        check("bp_hold_head", m.b_out, 1);
        check("bp_hold_pass", pass_cnt, 4);
        m.out_ready = 1;
        step();
        check("bp_pop_head", m.b_out, 2);
        check("bp_pop_ready", m.in_ready, 1);
        step();
        check("bp_third", m.b_out, 3);
        check("bp_third_valid", m.out_valid, 1);
        m.in_valid = 0;
        step();
        check("bp_empty", m.out_valid, 0);
        check("bp_pass", pass_cnt, 5);
        // clear then stream 20 random consistent pairs
        clr_cnt = 1;
        step();
        clr_cnt = 0;
        check("clr_pass", pass_cnt, 0);
        check("clr_err", err_cnt, 0);
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            m.in_valid = 1; m.a_in = a; m.sum_in = {1'b0, a} + {1'b0, b};
            step();
            check("stream_b", m.b_out, b);
            check("stream_err", m.err_out, 0);
            check("stream_valid", m.out_valid, 1);
        end
        m.in_valid = 0;
        step();
        check("stream_pass", pass_cnt, 20);
        check("stream_empty", m.out_valid, 0);
        // saturation on the 4-bit counter instance
        m4.out_ready = 1; m4.in_valid = 1; m4.sum_in = 9'd5; m4.a_in = 8'd10;
        repeat (20) step();
        check("sat_err", err4, 15);
        check("sat_pass", pass4, 0);
        clr4 = 1;
        step();
        clr4 = 0; m4.in_valid = 0;
        check("clr_wins", err4, 0);
        check("clr_keeps_fifo", m4.out_valid, 1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
